automat_multi: RTL and testbench

Parametrised multi-product coin vending controller, successor to the single-product cola machine. Accepts one coin code per cycle (0/5/10/50 units), latches a product selection on the first coin, dispenses when credit reaches that product's price, then returns change greedily as one 10 or 5 coin per cycle. Sits between the coin acceptor front end and the dispense/change actuators.

---
 rtl/automat_pkg.sv | 27 ++
 rtl/automat_change.sv | 51 +++++
 rtl/automat_multi.sv | 123 ++++++++++++
 tb/tb_automat_multi.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/automat_pkg.sv
// Shared coin/change codes, FSM state encodings and coin valuation for the vending controller.
// Credit is counted in 5-unit steps throughout.
package automat_pkg;

  localparam logic [1:0] M0  = 2'b00;
  localparam logic [1:0] M5  = 2'b01;
  localparam logic [1:0] B10 = 2'b10;
  localparam logic [1:0] B50 = 2'b11;

  localparam logic [1:0] REST_NONE = 2'b00;
  localparam logic [1:0] REST_5    = 2'b01;
  localparam logic [1:0] REST_10   = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_VEND   = 2'b01;
  localparam logic [1:0] ST_CHANGE = 2'b10;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      M5:      return 4'd1;
      B10:     return 4'd2;
      B50:     return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/automat_change.sv
// Greedy change down-counter: loaded with the remaining credit, pays one 10 (or final 5) per step.
// rest is registered; done flags the step that empties the counter.
module automat_change
  import automat_pkg::*;
#(
  parameter int CREDIT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  input  logic                step,
  output logic [1:0]          rest,
  output logic                done
);

  logic [CREDIT_W-1:0] cnt;
  logic [CREDIT_W-1:0] cnt_next;
  logic [1:0]          coin;

  always_comb begin
    coin     = REST_NONE;
    cnt_next = cnt;
    if (cnt >= CREDIT_W'(2)) begin
      coin     = REST_10;
      cnt_next = cnt - CREDIT_W'(2);
    end else if (cnt != '0) begin
      coin     = REST_5;
      cnt_next = cnt - CREDIT_W'(1);
    end
  end

  // An empty counter also reports done so the FSM can never stall in CHANGE.
  assign done = step && (cnt_next == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      rest <= REST_NONE;
    end else if (load) begin
      cnt  <= load_val;
      rest <= REST_NONE;
    end else if (step) begin
      cnt  <= cnt_next;
      rest <= coin;
    end else begin
      rest <= REST_NONE;
    end
  end

endmodule

// File: rtl/automat_multi.sv
// Multi-product coin vending FSM (IDLE/VEND/CHANGE); coins offered while busy are rejected.
// Optional refund-on-cancel path is built when AUTOMAT_MULTI_CANCEL_EN is defined.
module automat_multi
  import automat_pkg::*;
#(
  parameter int                        NPROD    = 2,
  parameter int                        CREDIT_W = 5,
  parameter logic [NPROD*CREDIT_W-1:0] PRICES   = {5'd6, 5'd4},
  parameter int                        SEL_W    = (NPROD > 1) ? $clog2(NPROD) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       bani,
  input  logic [SEL_W-1:0] sel,
  input  logic             cancel,
  output logic [NPROD-1:0] vend,
  output logic [1:0]       rest,
  output logic             coin_rej,
  output logic             busy
);

  logic [1:0]          state;
  logic [CREDIT_W-1:0] credit;
  logic [SEL_W-1:0]    sel_q;
  logic [CREDIT_W-1:0] sum;
  logic [SEL_W-1:0]    sel_raw;
  logic [SEL_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] price_eff;
  logic [NPROD-1:0]    vend_hot;
  logic                cancel_hit;
  logic                chg_load;
  logic [CREDIT_W-1:0] chg_val;
  logic                chg_done;

  assign sum     = credit + CREDIT_W'(coin_value(bani));
  assign sel_raw = (credit == '0) ? sel : sel_q;
  assign sel_idx = (32'(sel_raw) < NPROD) ? sel_raw : '0;

  always_comb begin
    price_eff = '0;
    vend_hot  = '0;
    for (int i = 0; i < NPROD; i++) begin
      if (sel_idx == SEL_W'(i)) begin
        price_eff   = PRICES[i*CREDIT_W +: CREDIT_W];
        vend_hot[i] = 1'b1;
      end
    end
  end

`ifdef AUTOMAT_MULTI_CANCEL_EN
  assign cancel_hit = cancel && (sum != '0);
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_hit    = 1'b0;
`endif

  // The vended price is taken off in IDLE, so in VEND credit already holds the change owed.
  assign chg_load = ((state == ST_IDLE) && cancel_hit) ||
                    ((state == ST_VEND) && (credit != '0));
  assign chg_val  = (state == ST_IDLE) ? sum : credit;

  automat_change #(.CREDIT_W(CREDIT_W)) u_change (
    .clk      (clk),
    .reset    (reset),
    .load     (chg_load),
    .load_val (chg_val),
    .step     (state == ST_CHANGE),
    .rest     (rest),
    .done     (chg_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      credit   <= '0;
      sel_q    <= '0;
      vend     <= '0;
      coin_rej <= 1'b0;
      busy     <= 1'b0;
    end else begin
      vend     <= '0;
      coin_rej <= (state != ST_IDLE) && (bani != M0);
      case (state)
        ST_IDLE: begin
          if ((credit == '0) && (bani != M0)) sel_q <= sel;
          if (cancel_hit) begin
            credit <= '0;
            state  <= ST_CHANGE;
            busy   <= 1'b1;
          end else if (sum >= price_eff) begin
            credit <= sum - price_eff;
            state  <= ST_VEND;
            vend   <= vend_hot;
            busy   <= 1'b1;
          end else begin
            credit <= sum;
          end
        end
        ST_VEND: begin
          credit <= '0;
          if (credit == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_CHANGE;
          end
        end
        ST_CHANGE: begin
          if (chg_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_automat_multi.sv
// Scoreboard bench for automat_multi: expected vend/rest/coin_rej events (value + cycle) are queued
// when stimulus is driven and matched against DUT output events as they appear.
module tb_automat_multi;

  typedef struct {
    int         kind;  // 0 vend, 1 rest, 2 coin_rej
    logic [7:0] val;
    int         at;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] bani = 2'b00;
  logic [0:0] sel = 1'b0;
  logic       cancel = 1'b0;
  logic [1:0] vend;
  logic [1:0] rest;
  logic       coin_rej;
  logic       busy;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  k;
  ev_t sb[$];

  automat_multi dut (
    .clk      (clk),
    .reset    (reset),
    .bani     (bani),
    .sel      (sel),
    .cancel   (cancel),
    .vend     (vend),
    .rest     (rest),
    .coin_rej (coin_rej),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic take(input int kind, input logic [7:0] val);
    ev_t e;
    if (sb.size() == 0) begin
      check(kind == 0 ? "extra_vend" : (kind == 1 ? "extra_rest" : "extra_rej"), 32'(val), 32'd0);
    end else begin
      e = sb.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_val", 32'(val), 32'(e.val));
      check("ev_cycle", cyc, e.at);
    end
  endtask

  // Output events sampled on the falling edge, in a fixed per-cycle order: vend, rest, coin_rej.
  always @(negedge clk) begin
    if (vend != 2'b00) take(0, 8'(vend));
    if (rest != 2'b00) take(1, 8'(rest));
    if (coin_rej)      take(2, 8'(coin_rej));
  end

  // Called at a falling edge; the coin is sampled at the next rising edge, after which cyc equals that edge.
  task automatic drive(input logic [1:0] b, input logic s, input logic c);
    bani   = b;
    sel    = s;
    cancel = c;
    @(negedge clk);
    bani   = 2'b00;
    cancel = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    repeat (4) @(negedge clk);
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_vend", 32'(vend), 0);
    check("rst_rest", 32'(rest), 0);
    check("rst_rej", 32'(coin_rej), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // 5+10+50 for product 0 (price 4): 13-4 = 9 -> 10,10,10,10,5
    drive(2'b01, 1'b0, 1'b0);
    drive(2'b10, 1'b0, 1'b0);
    k = cyc + 1;
    expect_ev(0, 8'h1, k);
    for (int i = 0; i < 4; i++) expect_ev(1, 8'h2, k + 2 + i);
    expect_ev(1, 8'h1, k + 6);
    drive(2'b11, 1'b0, 1'b0);
    check("t1_busy_vend", 32'(busy), 1);
    wait_until(k + 1);
    check("t1_busy_chg", 32'(busy), 1);
    check("t1_rest_gap", 32'(rest), 0);
    wait_until(k + 6);
    check("t1_busy_end", 32'(busy), 0);
    settle("t1_sb_empty");

    // Product 1 (price 6) with exact 10+10+10, then a new 50 accepted right after
    drive(2'b10, 1'b1, 1'b0);
    drive(2'b10, 1'b1, 1'b0);
    k = cyc + 1;
    expect_ev(0, 8'h2, k);
    drive(2'b10, 1'b1, 1'b0);
    check("t2_busy_vend", 32'(busy), 1);
    @(negedge clk);
    check("t2_busy_idle", 32'(busy), 0);
    k = cyc + 1;
    expect_ev(0, 8'h2, k);
    expect_ev(1, 8'h2, k + 2);
    expect_ev(1, 8'h2, k + 3);
    drive(2'b11, 1'b1, 1'b0);
    settle("t2_sb_empty");

    // Selection latched on the first coin; later sel changes ignored
    drive(2'b10, 1'b0, 1'b0);
    drive(2'b01, 1'b1, 1'b0);
    k = cyc + 1;
    expect_ev(0, 8'h1, k);
    drive(2'b01, 1'b1, 1'b0);
    settle("t3_sb_empty");

    // Coins during VEND and CHANGE rejected; change sequence unaffected (50-20 -> 10,10,10)
    k = cyc + 1;
    expect_ev(0, 8'h1, k);
    expect_ev(2, 8'h1, k + 1);
    expect_ev(1, 8'h2, k + 2);
    expect_ev(2, 8'h1, k + 2);
    expect_ev(1, 8'h2, k + 3);
    expect_ev(1, 8'h2, k + 4);
    drive(2'b11, 1'b0, 1'b0);
    drive(2'b11, 1'b0, 1'b0);
    drive(2'b11, 1'b0, 1'b0);
    wait_until(k + 4);
    check("t4_busy_end", 32'(busy), 0);
    settle("t4_sb_empty");

    // Reset in the middle of change: outputs cleared, no residual change afterwards
    k = cyc + 1;
    expect_ev(0, 8'h1, k);
    expect_ev(1, 8'h2, k + 2);
    expect_ev(1, 8'h2, k + 3);
    drive(2'b11, 1'b0, 1'b0);
    wait_until(k + 3);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_vend", 32'(vend), 0);
    check("t5_rst_rest", 32'(rest), 0);
    check("t5_rst_rej", 32'(coin_rej), 0);
    check("t5_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    drive(2'b10, 1'b0, 1'b0);
    k = cyc + 1;
    expect_ev(0, 8'h1, k);
    drive(2'b10, 1'b0, 1'b0);
    settle("t5_sb_empty");

    // 10, then cancel together with a 5
    drive(2'b10, 1'b0, 1'b0);
    k = cyc + 1;
`ifdef AUTOMAT_MULTI_CANCEL_EN
    expect_ev(1, 8'h2, k + 1);
    expect_ev(1, 8'h1, k + 2);
    drive(2'b01, 1'b0, 1'b1);
    check("t6_busy_refund", 32'(busy), 1);
    wait_until(k + 2);
    check("t6_busy_end", 32'(busy), 0);
`else
    drive(2'b01, 1'b0, 1'b1);
    check("t6_busy_held", 32'(busy), 0);
    k = cyc + 1;
    expect_ev(0, 8'h1, k);
    drive(2'b01, 1'b0, 1'b0);
`endif
    settle("t6_sb_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
